// File: rtl/axi_irq_ctrl_if.sv
// AXI4-Lite register-port bundle for the interrupt controller.
interface axi_irq_ctrl_if #(
  parameter int AXI_ADDR_BW_p = 12
);
  logic [AXI_ADDR_BW_p-1:0] awaddr;
  logic                     awvalid;
  logic                     awready;
  logic [31:0]              wdata;
  logic                     wvalid;
  logic                     wready;
  logic [1:0]               bresp;
  logic                     bvalid;
  logic                     bready;
  logic [AXI_ADDR_BW_p-1:0] araddr;
  logic                     arvalid;
  logic                     arready;
  logic [31:0]              rdata;
  logic [1:0]               rresp;
  logic                     rvalid;
  logic                     rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_irq_ctrl.sv
// AXI4-Lite interrupt controller: synchronizes sources, latches pending bits
// (edge or level), masks them with ENABLE and drives one registered CPU IRQ.
module axi_irq_ctrl #(
  parameter int AXI_ADDR_BW_p = 12,
  parameter int IRQ_NBR_p     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_irq_ctrl_if.slave        axi,
  input  logic [IRQ_NBR_p-1:0] i_irq_src,
  output logic                 o_irq
);
  localparam logic [2:0] SEL_RAW   = 3'd0;
  localparam logic [2:0] SEL_PEND  = 3'd1;
  localparam logic [2:0] SEL_ENA   = 3'd2;
  localparam logic [2:0] SEL_EDGE  = 3'd3;
  localparam logic [2:0] SEL_ACT   = 3'd4;
  localparam logic [2:0] SEL_SWSET = 3'd5;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic is_mapped(input logic [AXI_ADDR_BW_p-1:0] a);
    return ((a >> 5) == '0) && (a[4:2] <= SEL_SWSET);
  endfunction

  function automatic logic [31:0] zext(input logic [IRQ_NBR_p-1:0] v);
    logic [31:0] r;
    r = '0;
    r[IRQ_NBR_p-1:0] = v;
    return r;
  endfunction

  logic [IRQ_NBR_p-1:0]     sync1_q, sync_q, sync_dly_q;
  logic [IRQ_NBR_p-1:0]     pend_q, pend_d, ena_q, ena_d, edge_q, edge_d;
  logic [IRQ_NBR_p-1:0]     hw_set, sw_set, w1c, wbits;
  logic                     irq_q;
  logic                     aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic                     bvalid_q, bvalid_d;
  logic [1:0]               bresp_q, bresp_d;
  logic [AXI_ADDR_BW_p-1:0] awaddr_q, awaddr_d;
  logic [31:0]              wdata_q, wdata_d;
  logic                     rvalid_q, rvalid_d;
  logic [31:0]              rdata_q, rdata_d;
  logic [1:0]               rresp_q, rresp_d;
  logic                     aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
  logic                     unused_bits;

  assign axi.awready = ~rst & ~aw_held_q;
  assign axi.wready  = ~rst & ~w_held_q;
  assign axi.arready = ~rst & ~rvalid_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign o_irq       = irq_q;

  assign aw_hs  = axi.awvalid & axi.awready;
  assign w_hs   = axi.wvalid & axi.wready;
  assign b_hs   = bvalid_q & axi.bready;
  assign ar_hs  = axi.arvalid & axi.arready;
  assign r_hs   = rvalid_q & axi.rready;
  // Both beats held and no response outstanding: apply the write exactly once.
  assign commit = aw_held_q & w_held_q & ~bvalid_q;
  assign wbits  = wdata_q[IRQ_NBR_p-1:0];

  assign unused_bits = ^{awaddr_q[1:0], axi.araddr[1:0], wdata_q};

  assign hw_set = (edge_q & sync_q & ~sync_dly_q) | (~edge_q & sync_q);
  assign pend_d = (pend_q & ~w1c) | hw_set | sw_set;

  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    ena_d     = ena_q;
    edge_d    = edge_q;
    sw_set    = '0;
    w1c       = '0;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = axi.awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = axi.wdata;
    end
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = RESP_SLVERR;
      if (is_mapped(awaddr_q)) begin
        case (awaddr_q[4:2])
          SEL_PEND:  begin w1c    = wbits; bresp_d = RESP_OKAY; end
          SEL_ENA:   begin ena_d  = wbits; bresp_d = RESP_OKAY; end
          SEL_EDGE:  begin edge_d = wbits; bresp_d = RESP_OKAY; end
          SEL_SWSET: begin sw_set = wbits; bresp_d = RESP_OKAY; end
          default:   bresp_d = RESP_SLVERR;
        endcase
      end
    end
    if (b_hs) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b0;
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RESP_OKAY;
      if (!is_mapped(axi.araddr)) begin
        rresp_d = RESP_SLVERR;
      end else begin
        case (axi.araddr[4:2])
          SEL_RAW:  rdata_d = zext(sync_q);
          SEL_PEND: rdata_d = zext(pend_q);
          SEL_ENA:  rdata_d = zext(ena_q);
          SEL_EDGE: rdata_d = zext(edge_q);
          SEL_ACT:  rdata_d = zext(pend_q & ena_q);
          default:  rdata_d = '0;
        endcase
      end
    end else if (r_hs) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync_q     <= '0;
      sync_dly_q <= '0;
      pend_q     <= '0;
      ena_q      <= '0;
      edge_q     <= '0;
      irq_q      <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      sync1_q    <= i_irq_src;
      sync_q     <= sync1_q;
      sync_dly_q <= sync_q;
      pend_q     <= pend_d;
      ena_q      <= ena_d;
      edge_q     <= edge_d;
      irq_q      <= |(pend_q & ena_q);
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end
endmodule

// File: tb/tb_axi_irq_ctrl.sv
// Directed bench for axi_irq_ctrl with a cycle-level reference model of the
// register map, source sampling history and AXI channel occupancy.
module tb_axi_irq_ctrl;
  localparam int AW = 12;
  localparam int N  = 8;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] src = '0;
  logic         o_irq;
  int           n_chk = 0;
  int           n_fail = 0;
  bit           chk_en = 1'b0;

  axi_irq_ctrl_if #(.AXI_ADDR_BW_p(AW)) axi();

  axi_irq_ctrl #(.AXI_ADDR_BW_p(AW), .IRQ_NBR_p(N)) dut (
    .clk(clk), .rst(rst), .axi(axi), .i_irq_src(src), .o_irq(o_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: h1..h3 hold the source vector sampled 1..3 edges ago.
  logic [N-1:0]  h1, h2, h3, m_pend, m_ena, m_edge;
  logic          m_irq, m_aw, m_w, m_bv, m_rv;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wd;
  logic [1:0]    m_bresp;
  logic [N-1:0]  t_hw, t_clr, t_sw;

  always @(posedge clk) begin
    if (rst) begin
      h1 <= '0; h2 <= '0; h3 <= '0;
      m_pend <= '0; m_ena <= '0; m_edge <= '0; m_irq <= 1'b0;
      m_aw <= 1'b0; m_w <= 1'b0; m_bv <= 1'b0; m_rv <= 1'b0;
      m_addr <= '0; m_wd <= '0; m_bresp <= OKAY;
    end else begin
      t_hw = '0; t_clr = '0; t_sw = '0;
      for (int b = 0; b < N; b++)
        t_hw[b] = m_edge[b] ? (h2[b] & ~h3[b]) : h2[b];
      if (m_aw && m_w && !m_bv) begin
        m_bv    <= 1'b1;
        m_bresp <= OKAY;
        case ({m_addr[AW-1:2], 2'b00})
          12'h004: t_clr = m_wd[N-1:0];
          12'h008: m_ena <= m_wd[N-1:0];
          12'h00C: m_edge <= m_wd[N-1:0];
          12'h014: t_sw = m_wd[N-1:0];
          default: m_bresp <= SLVERR;
        endcase
      end
      m_pend <= (m_pend & ~t_clr) | t_hw | t_sw;
      m_irq  <= |(m_pend & m_ena);
      h1 <= src; h2 <= h1; h3 <= h2;
      if (axi.awvalid && !m_aw) begin m_aw <= 1'b1; m_addr <= axi.awaddr; end
      if (axi.wvalid && !m_w) begin m_w <= 1'b1; m_wd <= axi.wdata; end
      if (m_bv && axi.bready) begin m_aw <= 1'b0; m_w <= 1'b0; m_bv <= 1'b0; end
      if (axi.arvalid && !m_rv) m_rv <= 1'b1;
      else if (m_rv && axi.rready) m_rv <= 1'b0;
    end
  end

  function automatic void m_read(input logic [AW-1:0] a, output logic [31:0] d,
                                 output logic [1:0] r);
    d = '0;
    r = OKAY;
    case ({a[AW-1:2], 2'b00})
      12'h000: d = 32'(h2);
      12'h004: d = 32'(m_pend);
      12'h008: d = 32'(m_ena);
      12'h00C: d = 32'(m_edge);
      12'h010: d = 32'(m_pend & m_ena);
      12'h014: d = '0;
      default: r = SLVERR;
    endcase
  endfunction

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("cyc_o_irq", o_irq, m_irq);
      chk("cyc_awready", axi.awready, !rst && !m_aw);
      chk("cyc_wready", axi.wready, !rst && !m_w);
      chk("cyc_arready", axi.arready, !rst && !m_rv);
      chk("cyc_bvalid", axi.bvalid, m_bv);
      chk("cyc_rvalid", axi.rvalid, m_rv);
      if (m_bv) chk("cyc_bresp", axi.bresp, m_bresp);
    end
  end

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [1:0] er, input string nm);
    bit ah, wh;
    int t;
    @(negedge clk);
    axi.awaddr = a; axi.wdata = d; axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    t = 0;
    while ((axi.awvalid || axi.wvalid) && t < 20) begin
      ah = axi.awready;
      wh = axi.wready;
      @(negedge clk);
      if (ah) axi.awvalid = 1'b0;
      if (wh) axi.wvalid = 1'b0;
      t++;
    end
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    t = 0;
    while (!axi.bvalid && t < 20) begin @(negedge clk); t++; end
    chk({nm, "_bvalid"}, axi.bvalid, 1);
    chk({nm, "_bresp"}, axi.bresp, er);
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input logic [31:0] ed,
                          input logic [1:0] er, input string nm);
    logic [31:0] md;
    logic [1:0]  mr;
    int t;
    @(negedge clk);
    axi.araddr = a; axi.arvalid = 1'b1;
    t = 0;
    while (!axi.arready && t < 20) begin @(negedge clk); t++; end
    m_read(a, md, mr);
    @(negedge clk);
    axi.arvalid = 1'b0;
    t = 0;
    while (!axi.rvalid && t < 20) begin @(negedge clk); t++; end
    chk({nm, "_rvalid"}, axi.rvalid, 1);
    chk(nm, axi.rdata, ed);
    chk({nm, "_rresp"}, axi.rresp, er);
    chk({nm, "_model"}, md, ed);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b1; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b1;

    // Reset and idle
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_o_irq", o_irq, 0);
    chk("rst_awready", axi.awready, 0);
    chk("rst_arready", axi.arready, 0);
    chk("rst_rdata", axi.rdata, 0);
    chk("rst_bresp", axi.bresp, 0);
    chk("rst_rresp", axi.rresp, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_awready", axi.awready, 1);
    chk("post_rst_wready", axi.wready, 1);
    chk("post_rst_arready", axi.arready, 1);
    axi_read(12'h008, 32'h0, OKAY, "rd_enable_reset");
    src = 8'hFF;
    repeat (5) @(negedge clk);
    chk("idle_irq_masked", o_irq, 0);
    axi_read(12'h000, 32'hFF, OKAY, "rd_raw_all");
    axi_read(12'h004, 32'hFF, OKAY, "rd_pend_all_level");
    src = 8'h00;
    repeat (4) @(negedge clk);
    axi_write(12'h004, 32'hFF, OKAY, "wr_w1c_all");
    axi_read(12'h004, 32'h00, OKAY, "rd_pend_cleared");

    // Edge mode on bit 0
    axi_write(12'h00C, 32'h01, OKAY, "wr_edge0");
    axi_write(12'h008, 32'h01, OKAY, "wr_ena0");
    @(negedge clk); src[0] = 1'b1;
    @(negedge clk); src[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("edge_irq_n2", o_irq, 0);
    @(negedge clk);
    chk("edge_irq_n3", o_irq, 1);
    axi_read(12'h004, 32'h01, OKAY, "rd_pend_edge");
    src[0] = 1'b1;
    repeat (5) @(negedge clk);
    axi_write(12'h004, 32'h01, OKAY, "wr_w1c_edge");
    repeat (3) @(negedge clk);
    axi_read(12'h004, 32'h00, OKAY, "rd_pend_edge_held");
    chk("edge_irq_cleared", o_irq, 0);
    src[0] = 1'b0;

    // Level mode on bit 3
    axi_write(12'h00C, 32'h00, OKAY, "wr_edge_none");
    axi_write(12'h008, 32'h08, OKAY, "wr_ena3");
    src[3] = 1'b1;
    repeat (4) @(negedge clk);
    axi_read(12'h000, 32'h08, OKAY, "rd_raw_bit3");
    chk("level_irq", o_irq, 1);
    axi_write(12'h004, 32'h08, OKAY, "wr_w1c_level_high");
    axi_read(12'h004, 32'h08, OKAY, "rd_pend_level_repend");
    src[3] = 1'b0;
    repeat (4) @(negedge clk);
    axi_write(12'h004, 32'h08, OKAY, "wr_w1c_level_low");
    axi_read(12'h004, 32'h00, OKAY, "rd_pend_level_cleared");
    repeat (2) @(negedge clk);
    chk("level_irq_cleared", o_irq, 0);

    // Set-vs-clear race on bit 2, SWSET, ACTIVE
    axi_write(12'h00C, 32'h04, OKAY, "wr_edge2");
    axi_write(12'h014, 32'h04, OKAY, "wr_swset2");
    axi_read(12'h004, 32'h04, OKAY, "rd_pend_swset2");
    @(negedge clk); src[2] = 1'b1;
    axi_write(12'h004, 32'h04, OKAY, "wr_w1c_race");
    axi_read(12'h004, 32'h04, OKAY, "rd_pend_race");
    src[2] = 1'b0;
    axi_write(12'h014, 32'h80, OKAY, "wr_swset7");
    axi_read(12'h004, 32'h84, OKAY, "rd_pend_swset7");
    axi_write(12'h008, 32'h80, OKAY, "wr_ena7");
    axi_read(12'h010, 32'h80, OKAY, "rd_active");
    chk("active_irq", o_irq, 1);
    axi_write(12'h004, 32'hFF, OKAY, "wr_w1c_race_all");
    axi_read(12'h004, 32'h00, OKAY, "rd_pend_race_cleared");

    // W ahead of AW, bready held low
    @(negedge clk);
    axi.bready = 1'b0; axi.wdata = 32'h0A; axi.wvalid = 1'b1;
    chk("ord_wready_idle", axi.wready, 1);
    @(negedge clk); axi.wvalid = 1'b0;
    chk("ord_wready_held", axi.wready, 0);
    chk("ord_awready_idle", axi.awready, 1);
    @(negedge clk); axi.awaddr = 12'h00C; axi.awvalid = 1'b1;
    @(negedge clk); axi.awvalid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("ord_bvalid_stable", axi.bvalid, 1);
      chk("ord_bresp_okay", axi.bresp, OKAY);
      chk("ord_awready_low", axi.awready, 0);
      chk("ord_wready_low", axi.wready, 0);
      @(negedge clk);
    end
    axi.bready = 1'b1;
    @(negedge clk);
    chk("ord_bvalid_done", axi.bvalid, 0);
    chk("ord_awready_back", axi.awready, 1);
    chk("ord_wready_back", axi.wready, 1);
    axi_read(12'h00C, 32'h0A, OKAY, "rd_edge_ordered");

    // Decode errors
    axi_read(12'h018, 32'h0, SLVERR, "rd_unmapped_18");
    axi_write(12'h000, 32'hFF, SLVERR, "wr_raw_ro");
    axi_read(12'h000, 32'h00, OKAY, "rd_raw_unchanged");
    axi_read(12'h020, 32'h0, SLVERR, "rd_unmapped_20");
    axi_read(12'h80C, 32'h0, SLVERR, "rd_unmapped_high");
    axi_write(12'h010, 32'hFF, SLVERR, "wr_active_ro");
    axi_write(12'h808, 32'hFF, SLVERR, "wr_unmapped_high");
    axi_read(12'h008, 32'h80, OKAY, "rd_enable_unchanged");
    axi_write(12'h014, 32'hFFFF_FF01, OKAY, "wr_swset_wide");
    axi_read(12'h014, 32'h0, OKAY, "rd_swset_zero");
    axi_read(12'h004, 32'h01, OKAY, "rd_pend_swset_wide");
    axi_write(12'h004, 32'h01, OKAY, "wr_w1c_final");

    // Reset with both channels holding responses
    @(negedge clk);
    axi.rready = 1'b0; axi.bready = 1'b0;
    axi.araddr = 12'h008; axi.arvalid = 1'b1;
    axi.awaddr = 12'h008; axi.wdata = 32'h55; axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    @(negedge clk);
    axi.arvalid = 1'b0; axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    @(negedge clk);
    chk("mid_rvalid", axi.rvalid, 1);
    chk("mid_bvalid", axi.bvalid, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rvalid", axi.rvalid, 0);
    chk("mid_rst_bvalid", axi.bvalid, 0);
    chk("mid_rst_awready", axi.awready, 0);
    rst = 1'b0; axi.rready = 1'b1; axi.bready = 1'b1;
    @(negedge clk);
    chk("mid_post_arready", axi.arready, 1);
    axi_read(12'h008, 32'h0, OKAY, "rd_enable_after_rst");
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
